// File: rtl/btb_pkg.sv
// Shared types and helpers for the n-way branch target buffer.
// Holds the 2-bit predictor encoding and index/tag width helpers.
package btb_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   localparam int PC_LSB = 2;

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int xlen, input int sets);
      return xlen - PC_LSB - $clog2(sets);
   endfunction

   function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
      if (taken)
         return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
      return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
   endfunction

endpackage

// File: rtl/btb_nway_core_if.sv
// Fetch/execute facing bundle of the branch target buffer.
// Master drives lookups, updates and flush; slave returns responses.
interface btb_nway_core_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            lu_valid;
   logic [XLEN-1:0] lu_pc;
   logic            resp_valid;
   logic            resp_hit;
   logic            resp_taken;
   logic [XLEN-1:0] resp_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic [XLEN-1:0] upd_target;
   logic            upd_taken;

   modport master (
      output flush, lu_valid, lu_pc,
      output upd_valid, upd_pc, upd_target, upd_taken,
      input  resp_valid, resp_hit, resp_taken, resp_target
   );

   modport slave (
      input  flush, lu_valid, lu_pc,
      input  upd_valid, upd_pc, upd_target, upd_taken,
      output resp_valid, resp_hit, resp_taken, resp_target
   );
endinterface

// File: rtl/btb_lru_ages.sv
// Per-set true-LRU age update with two ordered touches.
// Victim is chosen against the ages after the first touch only.
module btb_lru_ages #(
   parameter int  WAYS = 2,
   localparam int AW   = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]         valid_i,
   input  logic [WAYS-1:0][AW-1:0] ages_i,
   input  logic                    t0_en_i,
   input  logic [AW-1:0]           t0_way_i,
   input  logic                    t1_en_i,
   input  logic [AW-1:0]           t1_way_i,
   output logic [WAYS-1:0][AW-1:0] ages_o,
   output logic [AW-1:0]           victim_o
);

   logic [WAYS-1:0][AW-1:0] mid;

   function automatic logic [WAYS-1:0][AW-1:0] touch(
      input logic [WAYS-1:0][AW-1:0] a,
      input logic [AW-1:0]           w
   );
      logic [WAYS-1:0][AW-1:0] r;
      r = a;
      for (int i = 0; i < WAYS; i++)
         if (a[i] < a[w])
            r[i] = a[i] + AW'(1);
      r[w] = '0;
      return r;
   endfunction

   always_comb begin
      mid = ages_i;
      if (t0_en_i)
         mid = touch(ages_i, t0_way_i);
   end

   // Invalid ways win over the LRU way; scan high-to-low so lowest index sticks.
   always_comb begin
      victim_o = '0;
      for (int i = 0; i < WAYS; i++)
         if (mid[i] == AW'(WAYS - 1))
            victim_o = AW'(i);
      for (int i = WAYS - 1; i >= 0; i--)
         if (!valid_i[i])
            victim_o = AW'(i);
   end

   always_comb begin
      ages_o = mid;
      if (t1_en_i)
         ages_o = touch(mid, t1_way_i);
   end

endmodule

// File: rtl/btb_nway_core.sv
// N-way set-associative BTB: 1-cycle registered lookup, execute-side
// updates, allocate-on-taken, true-LRU replacement and flush.
module btb_nway_core
   import btb_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   parameter int XLEN = 32
) (
   input logic             clk,
   input logic             rst,
   btb_nway_core_if.slave  bus
);

   localparam int IW = idx_w(SETS);
   localparam int TW = tag_w(XLEN, SETS);
   localparam int AW = $clog2(WAYS);

   logic [WAYS-1:0]         valid_q [SETS];
   logic [WAYS-1:0]         valid_d [SETS];
   logic [TW-1:0]           tag_q   [SETS][WAYS];
   logic [TW-1:0]           tag_d   [SETS][WAYS];
   logic [XLEN-1:0]         tgt_q   [SETS][WAYS];
   logic [XLEN-1:0]         tgt_d   [SETS][WAYS];
   ctr_e                    ctr_q   [SETS][WAYS];
   ctr_e                    ctr_d   [SETS][WAYS];
   logic [WAYS-1:0][AW-1:0] age_q   [SETS];
   logic [WAYS-1:0][AW-1:0] age_d   [SETS];
   logic [AW-1:0]           vict    [SETS];

   logic            rvalid_q, rhit_q, rtaken_q;
   logic [XLEN-1:0] rtgt_q;

   logic [IW-1:0] lu_idx, upd_idx;
   logic [TW-1:0] lu_tag, upd_tag;
   logic          lu_hit, upd_hit;
   logic [AW-1:0] lu_way, upd_way, wway;
   logic          upd_do, upd_touch;
   logic          unused_pc;

   assign lu_idx    = bus.lu_pc[IW+1:2];
   assign lu_tag    = bus.lu_pc[XLEN-1:IW+2];
   assign upd_idx   = bus.upd_pc[IW+1:2];
   assign upd_tag   = bus.upd_pc[XLEN-1:IW+2];
   assign unused_pc = ^{bus.lu_pc[1:0], bus.upd_pc[1:0]};

   always_comb begin
      lu_hit  = 1'b0;
      lu_way  = '0;
      upd_hit = 1'b0;
      upd_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lu_idx][w] && tag_q[lu_idx][w] == lu_tag) begin
            lu_hit = 1'b1;
            lu_way = AW'(w);
         end
         if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
            upd_hit = 1'b1;
            upd_way = AW'(w);
         end
      end
   end

   // Flush swallows any update issued in the same cycle.
   assign upd_do    = bus.upd_valid & ~bus.flush;
   assign upd_touch = upd_do & (upd_hit | bus.upd_taken);
   assign wway      = upd_hit ? upd_way : vict[upd_idx];

   for (genvar s = 0; s < SETS; s++) begin : g_set
      btb_lru_ages #(.WAYS(WAYS)) u_lru (
         .valid_i  (valid_q[s]),
         .ages_i   (age_q[s]),
         .t0_en_i  (bus.lu_valid && lu_hit && lu_idx == IW'(s)),
         .t0_way_i (lu_way),
         .t1_en_i  (upd_touch && upd_idx == IW'(s)),
         .t1_way_i (wway),
         .ages_o   (age_d[s]),
         .victim_o (vict[s])
      );
   end

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      if (bus.flush) begin
         for (int s = 0; s < SETS; s++)
            valid_d[s] = '0;
      end else if (upd_do && upd_hit) begin
         ctr_d[upd_idx][upd_way] =
            ctr_next(ctr_q[upd_idx][upd_way], bus.upd_taken);
         if (bus.upd_taken)
            tgt_d[upd_idx][upd_way] = bus.upd_target;
      end else if (upd_do && bus.upd_taken) begin
         valid_d[upd_idx][wway] = 1'b1;
         tag_d[upd_idx][wway]   = upd_tag;
         tgt_d[upd_idx][wway]   = bus.upd_target;
         ctr_d[upd_idx][wway]   = WEAK_T;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w] <= '0;
               tgt_q[s][w] <= '0;
               ctr_q[s][w] <= STRONG_NT;
               age_q[s][w] <= AW'(w);
            end
         end
         rvalid_q <= 1'b0;
         rhit_q   <= 1'b0;
         rtaken_q <= 1'b0;
         rtgt_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         tgt_q    <= tgt_d;
         ctr_q    <= ctr_d;
         age_q    <= age_d;
         rvalid_q <= bus.lu_valid;
         rhit_q   <= bus.lu_valid & lu_hit;
         rtaken_q <= bus.lu_valid & lu_hit &
                     (ctr_q[lu_idx][lu_way] inside {WEAK_T, STRONG_T});
         rtgt_q   <= (bus.lu_valid && lu_hit) ? tgt_q[lu_idx][lu_way] : '0;
      end
   end

   assign bus.resp_valid  = rvalid_q;
   assign bus.resp_hit    = rhit_q;
   assign bus.resp_taken  = rtaken_q;
   assign bus.resp_target = rtgt_q;

endmodule

// File: tb/tb_btb_nway_core.sv
// Scoreboard bench for btb_nway_core (WAYS=2, SETS=8, XLEN=32).
// Lookups push expectations; a negedge monitor pops and compares.
module tb_btb_nway_core;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   btb_nway_core_if #(.XLEN(32)) bus ();

   btb_nway_core #(.WAYS(2), .SETS(8), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, want, cyc);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid === 1'b1) begin
         if (sb.size() == 0 || sb[0].due != cyc) begin
            chk("unexpected_resp", bus.resp_valid, 0);
         end else begin
            e = sb.pop_front();
            chk({e.name, ".hit"},   bus.resp_hit,    e.hit);
            chk({e.name, ".taken"}, bus.resp_taken,  e.taken);
            chk({e.name, ".tgt"},   bus.resp_target, e.tgt);
         end
      end else begin
         chk("idle_zero",
             {bus.resp_valid, bus.resp_hit, bus.resp_taken, bus.resp_target},
             0);
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk({e.name, ".missing"}, bus.resp_valid, 1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lu(input string nm, input logic [31:0] pc,
                            input logic h, input logic t,
                            input logic [31:0] tg);
      bus.lu_valid = 1'b1;
      bus.lu_pc    = pc;
      sb.push_back('{hit: h, taken: t, tgt: tg, due: cyc + 1, name: nm});
   endtask

   task automatic look(input string nm, input logic [31:0] pc,
                       input logic h, input logic t, input logic [31:0] tg);
      expect_lu(nm, pc, h, t, tg);
      step();
      bus.lu_valid = 1'b0;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic [31:0] tg,
                          input logic tk);
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tg;
      bus.upd_taken  = tk;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tg,
                      input logic tk);
      set_upd(pc, tg, tk);
      step();
      bus.upd_valid = 1'b0;
   endtask

   initial begin
      bus.flush      = 1'b0;
      bus.lu_valid   = 1'b0;
      bus.lu_pc      = '0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_target = '0;
      bus.upd_taken  = 1'b0;
      rst            = 1'b1;

      // Requests during reset must be ignored entirely.
      bus.lu_valid = 1'b1;
      bus.lu_pc    = 32'h1000;
      set_upd(32'h1000, 32'h2000, 1'b1);
      step();
      step();
      chk("rst.valid", bus.resp_valid, 0);
      chk("rst.out", {bus.resp_hit, bus.resp_taken, bus.resp_target}, 0);
      rst           = 1'b0;
      bus.lu_valid  = 1'b0;
      bus.upd_valid = 1'b0;
      step();
      chk("rst.noresp", bus.resp_valid, 0);

      look("miss0", 32'h1000, 0, 0, 32'h0);

      upd(32'h1000, 32'h2000, 1'b1);
      look("alloc", 32'h1000, 1, 1, 32'h2000);

      upd(32'h1000, 32'h2000, 1'b0);
      upd(32'h1000, 32'h2000, 1'b0);
      look("nt2", 32'h1000, 1, 0, 32'h2000);
      upd(32'h1000, 32'h2000, 1'b0);
      look("nt_sat", 32'h1000, 1, 0, 32'h2000);
      upd(32'h1000, 32'h2004, 1'b1);
      look("t1", 32'h1000, 1, 0, 32'h2004);
      upd(32'h1000, 32'h2004, 1'b1);
      look("t2", 32'h1000, 1, 1, 32'h2004);

      upd(32'h1020, 32'h5000, 1'b1);
      look("lru.a", 32'h1000, 1, 1, 32'h2004);
      upd(32'h1040, 32'h6000, 1'b1);
      look("lru.evict", 32'h1020, 0, 0, 32'h0);
      look("lru.keep",  32'h1000, 1, 1, 32'h2004);
      look("lru.new",   32'h1040, 1, 1, 32'h6000);

      // Lookup hit and allocating update in set 0 on the same edge.
      expect_lu("same.lu", 32'h1000, 1, 1, 32'h2004);
      set_upd(32'h3000, 32'h7000, 1'b1);
      step();
      bus.lu_valid  = 1'b0;
      bus.upd_valid = 1'b0;
      upd(32'h1060, 32'h8000, 1'b1);
      look("same.old_lu", 32'h1000, 0, 0, 32'h0);
      look("same.victim", 32'h1040, 0, 0, 32'h0);
      look("same.mru",    32'h3000, 1, 1, 32'h7000);
      look("same.next",   32'h1060, 1, 1, 32'h8000);

      // Flush with a taken update and a lookup in the same cycle.
      bus.flush = 1'b1;
      expect_lu("flush.lu", 32'h3000, 1, 1, 32'h7000);
      set_upd(32'h1080, 32'h9000, 1'b1);
      step();
      bus.flush     = 1'b0;
      bus.lu_valid  = 1'b0;
      bus.upd_valid = 1'b0;
      look("flush.a", 32'h3000, 0, 0, 32'h0);
      look("flush.b", 32'h1060, 0, 0, 32'h0);
      look("flush.c", 32'h1080, 0, 0, 32'h0);

      upd(32'h1004, 32'h0000_a000, 1'b1);
      look("set1.hit",  32'h1004, 1, 1, 32'h0000_a000);
      look("set0.miss", 32'h1000, 0, 0, 32'h0);

      // Back-to-back lookups, one per cycle.
      expect_lu("b2b.0", 32'h1004, 1, 1, 32'h0000_a000);
      step();
      expect_lu("b2b.1", 32'h1008, 0, 0, 32'h0);
      step();
      bus.lu_valid = 1'b0;

      step();
      step();
      chk("sb.drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/btb_nway_core.md
# btb_nway_core

Parametrised N-way set-associative branch target buffer. It holds tag, target, valid and a 2-bit saturating predictor per way. It gives registered 1-cycle lookups to fetch and accepts resolved-branch updates from execute, using true-LRU replacement. It supersedes the fixed 2-way, 8-set BTB write path: it generalises ways and sets, owns its storage, and adds flush, allocate-on-taken-only and same-cycle lookup/update ordering.

## Interface
- WAYS, 2, associativity; power of two, 2..8
- SETS, 8, number of sets; power of two, 2..256
- XLEN, 32, PC/target width; tag width TAGW = XLEN-2-log2(SETS), so the defaults give 27 bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  clear all valid bits at the next edge
- lu_valid  in  1  lookup request
- lu_pc  in  XLEN  fetch PC; PC[1:0] ignored
- resp_valid  out  1  lookup response, one cycle after lu_valid
- resp_hit  out  1  tag match in a valid way
- resp_taken  out  1  counter[1] of the hit way; 0 on miss
- resp_target  out  XLEN  target of the hit way; 0 on miss
- upd_valid  in  1  resolved branch update
- upd_pc  in  XLEN  branch PC
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  actual outcome

## Operation
- Index = PC[log2(SETS)+1:2]. Tag = PC[XLEN-1:log2(SETS)+2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. A taken outcome increments and saturates at 11. A not-taken outcome decrements and saturates at 00.
- LRU: each set has WAYS age fields of log2(WAYS) bits each, always a permutation of 0..WAYS-1. Age 0 is MRU; age WAYS-1 is LRU.
- Touching way w: every age less than age[w] increments, then age[w] becomes 0.
- Lookup hit: registers hit/taken/target and touches the hit way. A miss touches nothing.
- Update hit: steps the counter. If upd_taken, target is overwritten with upd_target. The way is touched.
- Update miss with upd_taken=1: allocates a victim way. Victim = lowest-index invalid way, else the way with age WAYS-1. The allocated way gets tag, target, valid=1 and counter 10, and is touched.
- Update miss with upd_taken=0: no state change.
- At most one way matches, because allocation only occurs on a miss.
- flush: clears all valid bits. Counters, tags and ages are retained. If flush and upd_valid occur in the same cycle, flush wins and the update is dropped. A lookup in the flush cycle still completes against the pre-flush contents.

## Timing
- Lookup latency is 1 cycle: lu_valid at edge N gives resp_* valid from edge N+1. lu_valid is accepted every cycle and there is no backpressure.
- Array reads are pre-edge (old data). An update at edge N is visible to lookups issued at N+1 or later.
- Lookup and update in the same set in the same cycle: the lookup touch is applied first, then the update touch, so the update way ends as MRU. If both target the same way, it is touched once.
- When resp_valid=0, resp_hit, resp_taken and resp_target are 0.
- Reset (rst high at an edge) overrides everything, including mid-stream requests:
  - all valid bits, counters, tags and targets cleared
  - ages[w] = w in every set
  - resp_valid, resp_hit, resp_taken, resp_target = 0
  - a lookup issued in the reset cycle produces no response

## Structure
- Package btb_pkg holds:
  - the counter enum (STRONG_NT..STRONG_T)
  - the counter next-state function
  - localparam helpers for index and tag widths
- One sub-module, btb_lru_ages. It is per-set combinational: it takes the current ages plus two optional touch ways in order, and returns the next ages and the victim.
- Storage is flops, not inferred RAM, because reset must clear valid bits.

## Test plan
- Reset, then lookup 0x0000_1000 -> resp_valid=1 and resp_hit=0 one cycle later; all outputs were 0 during reset.
- Update pc=0x1000, target=0x2000, taken=1, then lookup 0x1000 -> hit, taken=1 (counter 10), target=0x2000.
- Same PC: update not-taken twice -> lookup gives taken=0 (counter 00). A third not-taken keeps it at 00. Two taken updates give taken=1.
- WAYS=2, SETS=8: allocate 0x1000 and 0x1020, look up 0x1000, then allocate 0x1040 -> 0x1020 is evicted; 0x1000 and 0x1040 still hit.
- Same cycle: lookup 0x1000 plus update of a miss PC 0x3000 taken in set 0 -> lookup hits with old data; 0x3000 becomes MRU; the victim is chosen against the post-lookup ages.
- Flush asserted together with a taken update -> every subsequent lookup misses and the update is not installed; a lookup issued in the flush cycle still hits.
